alu_word_seq: RTL and testbench

Sequencer that drives the 8-bit alu_65ce02 datapath through two byte passes to execute the 65CE02 16-bit word operations: add, subtract, increment, decrement, shift and rotate. It latches 16-bit operands and issues the low and high bytes in the correct order, chaining carry between them. It then assembles the 16-bit result and the N/Z/C/V flags. It sits between the core's microcode/decoder and the shared ALU instance, and owns the ALU control inputs while busy.

---
 rtl/alu_word_seq_pkg.sv | 23 ++
 rtl/alu_65ce02.sv | 32 +++
 rtl/alu_word_seq.sv | 116 +++++++++++
 tb/tb_alu_word_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_word_seq_pkg.sv
// alu_word_seq_pkg: command codes, ALU op constants and sequencer states for the word sequencer
package alu_word_seq_pkg;
    typedef enum logic [2:0] {
        CMD_ADDW = 3'b000,
        CMD_SUBW = 3'b001,
        CMD_INW  = 3'b010,
        CMD_DEW  = 3'b011,
        CMD_ASW  = 3'b100,
        CMD_ROW  = 3'b101,
        CMD_LSRW = 3'b110,
        CMD_ASRW = 3'b111
    } cmd_e;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_DBL  = 4'b1011;
    localparam logic [3:0] OP_PASS = 4'b1111;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE1  = 2'd1,
        S_ISSUE2  = 2'd2,
        S_COLLECT = 2'd3
    } state_e;
endpackage

// File: rtl/alu_65ce02.sv
// alu_65ce02: 8-bit ALU with registered OUT/CO/V; op[1:0] picks the logic term, op[3:2] the B term
module alu_65ce02 (
    input  logic       clk,
    input  logic       RDY,
    input  logic [3:0] op,
    input  logic       right,
    input  logic       arith,
    input  logic [7:0] AI,
    input  logic [7:0] BI,
    input  logic       CI,
    input  logic       BCD,
    output logic [7:0] OUT,
    output logic       CO,
    output logic       V
);
    logic [7:0] w_logic;
    logic [7:0] w_b;
    logic [8:0] w_sum;
    always_comb begin
        w_logic = op[1:0] == 2'b00 ? (AI | BI) : op[1:0] == 2'b01 ? (AI & BI) : op[1:0] == 2'b10 ? (AI ^ BI) : AI;
        w_b     = op[3:2] == 2'b00 ? BI : op[3:2] == 2'b01 ? ~BI : op[3:2] == 2'b10 ? w_logic : 8'h00;
        w_sum   = {1'b0, w_logic} + {1'b0, w_b} + {8'h00, CI};
    end
    // Decimal mode leaves V undefined; it is forced low there.
    always_ff @(posedge clk) begin
        if (RDY) begin
            OUT <= right ? {(arith ? AI[7] : CI), AI[7:1]} : w_sum[7:0];
            CO  <= right ? AI[0] : w_sum[8];
            V   <= ~right & ~BCD & (w_logic[7] == w_b[7]) & (w_logic[7] != w_sum[7]);
        end
    end
endmodule

// File: rtl/alu_word_seq.sv
// alu_word_seq: runs 16-bit word ops as two chained byte passes through the shared 8-bit ALU
module alu_word_seq
    import alu_word_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RDY,
    input  logic        start,
    input  logic [2:0]  cmd,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        ci_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        co_out,
    output logic        n_out,
    output logic        z_out,
    output logic        v_out,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic        alu_arith,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_bcd,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    input  logic        alu_v
);
    state_e      r_state;
    state_e      w_next;
    cmd_e        r_cmd;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_ci;
    logic [7:0]  r_b1;
    logic [15:0] r_result;
    logic        r_co;
    logic        r_n;
    logic        r_z;
    logic        r_v;
    logic        r_done;
    logic        w_right;
    logic        w_ab;
    logic        w_first;
    logic        w_issue;
    logic        w_hi;
    logic [3:0]  w_op;
    logic        w_ci1;
    logic [15:0] w_word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else if (RDY) r_state <= w_next;
    end
    // Right shifts walk high byte first so the low byte receives old A[8] as its carry.
    always_comb begin
        w_right = r_cmd == CMD_LSRW || r_cmd == CMD_ASRW;
        w_ab    = r_cmd == CMD_ADDW || r_cmd == CMD_SUBW;
        w_first = r_state == S_ISSUE1;
        w_issue = r_state == S_ISSUE1 || r_state == S_ISSUE2;
        w_hi    = w_first == w_right;
        w_op    = w_right ? OP_PASS : (r_cmd == CMD_ADDW || r_cmd == CMD_INW) ? OP_ADD :
                  (r_cmd == CMD_SUBW || r_cmd == CMD_DEW) ? OP_SUB : OP_DBL;
        w_ci1   = (w_ab || r_cmd == CMD_ROW) ? r_ci : r_cmd == CMD_INW;
        w_word  = w_right ? {r_b1, alu_out} : {alu_out, r_b1};
        w_next  = r_state == S_IDLE ? (start ? S_ISSUE1 : S_IDLE) :
                  r_state == S_ISSUE1 ? S_ISSUE2 : r_state == S_ISSUE2 ? S_COLLECT : S_IDLE;
        alu_op    = w_issue ? w_op : OP_PASS;
        alu_right = w_issue & w_right;
        alu_arith = w_first & (r_cmd == CMD_ASRW);
        alu_ai    = w_issue ? (w_hi ? r_a[15:8] : r_a[7:0]) : 8'h00;
        alu_bi    = (w_issue & w_ab) ? (w_hi ? r_b[15:8] : r_b[7:0]) : 8'h00;
        alu_ci    = w_first ? w_ci1 : (r_state == S_ISSUE2) & alu_co;
        alu_bcd   = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd    <= CMD_ADDW;
            r_a      <= '0;
            r_b      <= '0;
            r_ci     <= 1'b0;
            r_b1     <= '0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else if (RDY) begin
            if (r_state == S_IDLE && start) begin
                r_cmd  <= cmd_e'(cmd);
                r_a    <= a_in;
                r_b    <= b_in;
                r_ci   <= ci_in;
                r_done <= 1'b0;
            end
            if (r_state == S_ISSUE2) r_b1 <= alu_out;
            if (r_state == S_COLLECT) begin
                r_result <= w_word;
                r_co     <= alu_co;
                r_n      <= w_word[15];
                r_z      <= w_word == 16'h0000;
                r_v      <= w_ab & alu_v;
                r_done   <= 1'b1;
            end
        end
    end
    assign busy   = r_state != S_IDLE;
    assign done   = r_done;
    assign result = r_result;
    assign co_out = r_co;
    assign n_out  = r_n;
    assign z_out  = r_z;
    assign v_out  = r_v;
endmodule

// File: tb/tb_alu_word_seq.sv
// tb_alu_word_seq: scoreboard bench for the word sequencer driving a real byte ALU
module tb_alu_word_seq;
    import alu_word_seq_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RDY = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  cmd = 3'b000;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        ci_in = 1'b0;
    logic        busy, done, co_out, n_out, z_out, v_out;
    logic [15:0] result;
    logic [3:0]  alu_op;
    logic        alu_right, alu_arith, alu_ci, alu_bcd, alu_co, alu_v;
    logic [7:0]  alu_ai, alu_bi, alu_out;
    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        n;
        logic        z;
        logic        v;
        int          cyc;
    } exp_t;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    alu_word_seq dut (
        .clk(clk), .rst_n(rst_n), .RDY(RDY), .start(start), .cmd(cmd),
        .a_in(a_in), .b_in(b_in), .ci_in(ci_in), .busy(busy), .done(done),
        .result(result), .co_out(co_out), .n_out(n_out), .z_out(z_out), .v_out(v_out),
        .alu_op(alu_op), .alu_right(alu_right), .alu_arith(alu_arith), .alu_ai(alu_ai),
        .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_out(alu_out),
        .alu_co(alu_co), .alu_v(alu_v)
    );
    alu_65ce02 alu (
        .clk(clk), .RDY(RDY), .op(alu_op), .right(alu_right), .arith(alu_arith),
        .AI(alu_ai), .BI(alu_bi), .CI(alu_ci), .BCD(alu_bcd),
        .OUT(alu_out), .CO(alu_co), .V(alu_v)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && !prev_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %0h expected no completion", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("co", co_out, e.co);
                chk("n", n_out, e.n);
                chk("z", z_out, e.z);
                chk("v", v_out, e.v);
                chk("latency", cyc, e.cyc);
            end
        end
        prev_done = done;
    end
    task automatic push_exp(input logic [15:0] r, input logic co, input logic v, input int lat);
        exp_t e;
        e.res = r;
        e.co  = co;
        e.n   = r[15];
        e.z   = (r == 16'h0000);
        e.v   = v;
        e.cyc = cyc + lat;
        q.push_back(e);
    endtask
    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", done, 1);
    endtask
    task automatic run(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] r, input logic co, input logic v, input int stall);
        cmd = c;
        a_in = a;
        b_in = b;
        ci_in = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(r, co, v, 3 + stall);
        if (stall > 0) begin
            @(posedge clk);
            #1;
            RDY = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_busy", busy, 1);
                chk("stall_done", done, 0);
                chk("stall_op", alu_op, OP_ADD);
                chk("stall_ai", alu_ai, a[15:8]);
                chk("stall_bi", alu_bi, b[15:8]);
                chk("stall_alu_out", alu_out, r[7:0]);
                @(posedge clk);
                #1;
            end
            RDY = 1'b1;
        end
        wait_done();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_co", co_out, 0);
        chk("rst_n", n_out, 0);
        chk("rst_z", z_out, 0);
        chk("rst_v", v_out, 0);
        chk("rst_alu_op", alu_op, OP_PASS);
        chk("rst_alu_bcd", alu_bcd, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(CMD_ADDW, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0, 0);
        run(CMD_SUBW, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        run(CMD_INW,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run(CMD_DEW,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
        run(CMD_ASRW, 16'h8001, 16'h0000, 1'b0, 16'hC000, 1'b1, 1'b0, 0);
        run(CMD_LSRW, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1, 1'b0, 0);
        run(CMD_ASW,  16'h4000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 0);
        run(CMD_ROW,  16'h8000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 0);
        run(CMD_ADDW, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0, 3);
        // start held high with new operands while busy must not launch a second op
        cmd = CMD_ADDW;
        a_in = 16'h0102;
        b_in = 16'h0304;
        ci_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h0406, 1'b0, 1'b0, 3);
        cmd = CMD_INW;
        a_in = 16'hAAAA;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_busy", busy, 0);
        chk("ignored_result", result, 16'h0406);
        cmd = CMD_ROW;
        a_in = 16'h8000;
        ci_in = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(16'h0001, 1'b1, 1'b0, 3);
        wait_done();
        cmd = CMD_ADDW;
        a_in = 16'h12FF;
        b_in = 16'h0001;
        ci_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_co", co_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(CMD_INW, 16'h1234, 16'h0000, 1'b0, 16'h1235, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
